// File: rtl/mips_dump_pkg.sv
// Shared definitions for the MIPS end-of-run state dumper: FSM encoding,
// beat-kind codes and the signature update used by the dump engine.
package mips_dump_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_FREEZE  = 3'd2,
    ST_REG_RD  = 3'd3,
    ST_REG_OUT = 3'd4,
    ST_MEM_RD  = 3'd5,
    ST_MEM_OUT = 3'd6,
    ST_DONE    = 3'd7
  } state_e;

  localparam logic OUT_KIND_REG = 1'b0;
  localparam logic OUT_KIND_MEM = 1'b1;

  // Rotate the low w bits of cs left by one, then XOR in d. Operands are
  // carried in 64 bits so one function serves any word width up to 64.
  function automatic logic [63:0] rotl1_xor(input logic [63:0] cs,
                                            input logic [63:0] d,
                                            input int          w);
    logic [63:0] mask;
    logic [63:0] csm;
    logic [63:0] rot;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    csm  = cs & mask;
    rot  = ((csm << 1) | (csm >> (w - 1))) & mask;
    return (rot ^ d) & mask;
  endfunction

endpackage

// File: rtl/dump_read_port.sv
// Read-port adapter: forwards the dump address and raises data_ok once the
// read data belonging to that address is valid (READ_LAT of 0 or 1).
module dump_read_port #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              data_ok,
  output logic [DATA_W-1:0] data
);

  logic ok_q;
  logic ok_d;

  assign rd_addr = addr;
  assign data    = rd_data;
  assign data_ok = (READ_LAT == 0) ? req : ok_q;

  // One-cycle strobe in the second cycle of a request so a held request
  // produces exactly one data_ok per read.
  always_comb begin
    ok_d = req && !ok_q;
  end

  // Latency strobe register.
  always_ff @(posedge clk) begin
    if (!reset) ok_q <= 1'b0;
    else        ok_q <= ok_d;
  end

endmodule

// File: rtl/mips_state_dumper.sv
// End-of-run dump engine: runs the core for run_cycles, freezes it, then
// streams every register and the first MEM_WORDS memory words on a
// valid/ready channel while folding them into a rotate-XOR signature.
module mips_state_dumper
  import mips_dump_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 11,
  parameter int CYC_W     = 16,
  parameter int READ_LAT  = 1,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CYC_W-1:0]  run_cycles,
  output logic              cpu_hold,
  output logic [4:0]        reg_rd_addr,
  input  logic [DATA_W-1:0] reg_rd_data,
  output logic [IDX_W-1:0]  mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_kind,
  output logic [IDX_W-1:0]  out_index,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int LAST_REG = NUM_REGS - 1;
  localparam int LAST_MEM = (MEM_WORDS > 0) ? MEM_WORDS - 1 : 0;

  state_e            state_q, state_d;
  logic [CYC_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  i_q, i_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              out_valid_q, out_valid_d;
  logic              out_kind_q, out_kind_d;
  logic [IDX_W-1:0]  out_index_q, out_index_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              rp_req;
  logic [IDX_W-1:0]  rp_addr;
  logic [DATA_W-1:0] rp_rd_data;
  logic              rp_ok;
  logic [DATA_W-1:0] rp_data;

  // A single read port serves both sources; out_kind selects which one.
  assign reg_rd_addr = (out_kind_q == OUT_KIND_REG) ? 5'(rp_addr) : 5'd0;
  assign mem_rd_addr = (out_kind_q == OUT_KIND_MEM) ? rp_addr : '0;
  assign rp_rd_data  = (out_kind_q == OUT_KIND_MEM) ? mem_rd_data : reg_rd_data;

  dump_read_port #(
    .ADDR_W   (IDX_W),
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_port (
    .clk     (clk),
    .reset   (reset),
    .req     (rp_req),
    .addr    (i_q),
    .rd_addr (rp_addr),
    .rd_data (rp_rd_data),
    .data_ok (rp_ok),
    .data    (rp_data)
  );

  // Next-state and next-output logic of the dump sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    cpu_hold_d  = cpu_hold_q;
    out_valid_d = out_valid_q;
    out_kind_d  = out_kind_q;
    out_index_d = out_index_q;
    out_data_d  = out_data_q;
    checksum_d  = checksum_q;
    done_d      = done_q;
    rp_req      = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          cnt_d      = run_cycles;
          checksum_d = '0;
          done_d     = 1'b0;
          if (run_cycles != '0) begin
            state_d    = ST_RUN;
            cpu_hold_d = 1'b0;
          end else begin
            state_d    = ST_FREEZE;
            cpu_hold_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CYC_W'(1);
        if (cnt_q == CYC_W'(1)) begin
          state_d    = ST_FREEZE;
          cpu_hold_d = 1'b1;
        end
      end
      ST_FREEZE: begin
        i_d        = '0;
        out_kind_d = OUT_KIND_REG;
        state_d    = ST_REG_RD;
      end
      ST_REG_RD, ST_MEM_RD: begin
        rp_req = 1'b1;
        if (rp_ok) begin
          out_data_d  = rp_data;
          out_index_d = i_q;
          out_valid_d = 1'b1;
          state_d     = (state_q == ST_REG_RD) ? ST_REG_OUT : ST_MEM_OUT;
        end
      end
      ST_REG_OUT: begin
        if (out_ready) begin
          checksum_d  = DATA_W'(rotl1_xor(64'(checksum_q), 64'(out_data_q), DATA_W));
          out_valid_d = 1'b0;
          if (i_q == IDX_W'(LAST_REG)) begin
            i_d = '0;
            if (MEM_WORDS == 0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              out_kind_d = OUT_KIND_MEM;
              state_d    = ST_MEM_RD;
            end
          end else begin
            i_d     = i_q + IDX_W'(1);
            state_d = ST_REG_RD;
          end
        end
      end
      ST_MEM_OUT: begin
        if (out_ready) begin
          checksum_d  = DATA_W'(rotl1_xor(64'(checksum_q), 64'(out_data_q), DATA_W));
          out_valid_d = 1'b0;
          if (i_q == IDX_W'(LAST_MEM)) begin
            i_d     = '0;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            i_d     = i_q + IDX_W'(1);
            state_d = ST_MEM_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = !((state_d == ST_IDLE) || (state_d == ST_DONE));
  end

  // State and registered outputs; reset clears everything back to IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      cpu_hold_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_kind_q  <= OUT_KIND_REG;
      out_index_q <= '0;
      out_data_q  <= '0;
      checksum_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      cpu_hold_q  <= cpu_hold_d;
      out_valid_q <= out_valid_d;
      out_kind_q  <= out_kind_d;
      out_index_q <= out_index_d;
      out_data_q  <= out_data_d;
      checksum_q  <= checksum_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_hold  = cpu_hold_q;
  assign out_valid = out_valid_q;
  assign out_kind  = out_kind_q;
  assign out_index = out_index_q;
  assign out_data  = out_data_q;
  assign checksum  = checksum_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule
